// File: rtl/nx_stream_distributor_if.sv
// nx_stream_distributor_if: inbound stream plus four outbound streams; slave = distributor side, master = upstream/consumer side
interface nx_stream_distributor_if #(
  parameter int STREAM_WIDTH = 32
);
  logic [STREAM_WIDTH-1:0] inbound_data_i;
  logic [1:0]              inbound_dir_i;
  logic                    inbound_valid_i;
  logic                    inbound_ready_o;
  logic [STREAM_WIDTH-1:0] dist_north_data_o;
  logic                    dist_north_valid_o;
  logic                    dist_north_ready_i;
  logic [STREAM_WIDTH-1:0] dist_east_data_o;
  logic                    dist_east_valid_o;
  logic                    dist_east_ready_i;
  logic [STREAM_WIDTH-1:0] dist_south_data_o;
  logic                    dist_south_valid_o;
  logic                    dist_south_ready_i;
  logic [STREAM_WIDTH-1:0] dist_west_data_o;
  logic                    dist_west_valid_o;
  logic                    dist_west_ready_i;
  modport slave (
    input  inbound_data_i, inbound_dir_i, inbound_valid_i,
    output inbound_ready_o,
    output dist_north_data_o, dist_north_valid_o,
    input  dist_north_ready_i,
    output dist_east_data_o, dist_east_valid_o,
    input  dist_east_ready_i,
    output dist_south_data_o, dist_south_valid_o,
    input  dist_south_ready_i,
    output dist_west_data_o, dist_west_valid_o,
    input  dist_west_ready_i
  );
  modport master (
    output inbound_data_i, inbound_dir_i, inbound_valid_i,
    input  inbound_ready_o,
    input  dist_north_data_o, dist_north_valid_o,
    output dist_north_ready_i,
    input  dist_east_data_o, dist_east_valid_o,
    output dist_east_ready_i,
    input  dist_south_data_o, dist_south_valid_o,
    output dist_south_ready_i,
    input  dist_west_data_o, dist_west_valid_o,
    output dist_west_ready_i
  );
endinterface

// File: rtl/nx_stream_distributor.sv
// nx_stream_distributor: routes inbound messages by 2-bit dir into four per-direction FIFOs (ports: clk_i, rst_i, bus slave, idle_o)
module nx_stream_distributor #(
  parameter int STREAM_WIDTH = 32,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  nx_stream_distributor_if.slave bus,
  output logic                   idle_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [STREAM_WIDTH-1:0] r_mem [4][FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr [4];
  logic [AW-1:0]           r_rd_ptr [4];
  logic [CW-1:0]           r_cnt [4];
  logic [3:0]              w_rdy_out;
  logic [3:0]              w_vld_out;
  logic [3:0]              w_full;
  logic [3:0]              w_pop;
  logic [3:0]              w_push;
  logic                    w_push_any;
  assign w_rdy_out = {bus.dist_west_ready_i, bus.dist_south_ready_i, bus.dist_east_ready_i, bus.dist_north_ready_i};
  // Ready depends only on the addressed FIFO's registered fullness, so a same-cycle pop never frees space.
  assign bus.inbound_ready_o = !w_full[bus.inbound_dir_i];
  assign w_push_any = bus.inbound_valid_i && bus.inbound_ready_o;
  assign idle_o = (w_vld_out == 4'd0) && !bus.inbound_valid_i;
  assign bus.dist_north_data_o  = r_mem[0][r_rd_ptr[0]];
  assign bus.dist_east_data_o   = r_mem[1][r_rd_ptr[1]];
  assign bus.dist_south_data_o  = r_mem[2][r_rd_ptr[2]];
  assign bus.dist_west_data_o   = r_mem[3][r_rd_ptr[3]];
  assign bus.dist_north_valid_o = w_vld_out[0];
  assign bus.dist_east_valid_o  = w_vld_out[1];
  assign bus.dist_south_valid_o = w_vld_out[2];
  assign bus.dist_west_valid_o  = w_vld_out[3];
  for (genvar d = 0; d < 4; d++) begin : g_dir
    assign w_full[d]    = r_cnt[d] == CW'(FIFO_DEPTH);
    assign w_vld_out[d] = r_cnt[d] != '0;
    assign w_pop[d]     = w_vld_out[d] && w_rdy_out[d];
    assign w_push[d]    = w_push_any && (bus.inbound_dir_i == 2'(d));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push[d] && w_full[d]));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(w_pop[d] && !w_vld_out[d]));
  end
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < 4; d++) begin
      if (rst_i) begin
        r_wr_ptr[d] <= '0;
        r_rd_ptr[d] <= '0;
        r_cnt[d]    <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) r_mem[d][k] <= '0;
      end else begin
        if (w_push[d]) begin
          r_mem[d][r_wr_ptr[d]] <= bus.inbound_data_i;
          r_wr_ptr[d]           <= r_wr_ptr[d] + 1'b1;
        end
        if (w_pop[d]) r_rd_ptr[d] <= r_rd_ptr[d] + 1'b1;
        r_cnt[d] <= r_cnt[d] + CW'(w_push[d]) - CW'(w_pop[d]);
      end
    end
  end
endmodule

// File: tb/tb_nx_stream_distributor.sv
// tb_nx_stream_distributor: queue-model bench with directed scenarios and randomized traffic
module tb_nx_stream_distributor;
  localparam int W = 32;
  localparam int D = 2;
  typedef logic [W-1:0] dq_t[$];
  logic clk_i = 0;
  logic rst_i = 1;
  logic idle_o;
  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  bit m_acc = 0;
  dq_t q[4];
  always #5 clk_i = ~clk_i;
  nx_stream_distributor_if #(.STREAM_WIDTH(W)) bus();
  nx_stream_distributor #(.STREAM_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .idle_o(idle_o)
  );
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] dout(int d);
    case (d)
      0: return bus.dist_north_data_o;
      1: return bus.dist_east_data_o;
      2: return bus.dist_south_data_o;
      default: return bus.dist_west_data_o;
    endcase
  endfunction
  function automatic logic vld(int d);
    case (d)
      0: return bus.dist_north_valid_o;
      1: return bus.dist_east_valid_o;
      2: return bus.dist_south_valid_o;
      default: return bus.dist_west_valid_o;
    endcase
  endfunction
  function automatic logic rdy(int d);
    case (d)
      0: return bus.dist_north_ready_i;
      1: return bus.dist_east_ready_i;
      2: return bus.dist_south_ready_i;
      default: return bus.dist_west_ready_i;
    endcase
  endfunction
  task automatic set_rdy(logic [3:0] r);
    bus.dist_north_ready_i = r[0];
    bus.dist_east_ready_i  = r[1];
    bus.dist_south_ready_i = r[2];
    bus.dist_west_ready_i  = r[3];
  endtask
  task automatic drive(logic v, logic [1:0] dir, logic [W-1:0] data);
    bus.inbound_valid_i = v;
    bus.inbound_dir_i   = dir;
    bus.inbound_data_i  = data;
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  // Reference: per-direction FIFOs as queues; a push needs room before the edge, pops drain heads.
  initial forever begin
    bit push;
    int dd;
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      m_acc = 0;
    end else begin
      dd = int'(bus.inbound_dir_i);
      push = bus.inbound_valid_i && (q[dd].size() < D);
      for (int i = 0; i < 4; i++)
        if (q[i].size() > 0 && rdy(i)) void'(q[i].pop_front());
      if (push) q[dd].push_back(bus.inbound_data_i);
      m_acc = push;
    end
  end
  initial forever begin
    bit any;
    bit stall;
    logic [W-1:0] s_data;
    logic [1:0] s_dir;
    @(negedge clk_i);
    if (chk_en) begin
      any = 0;
      for (int i = 0; i < 4; i++) begin
        chk("valid", vld(i), q[i].size() != 0);
        if (q[i].size() != 0) chk("data", dout(i), q[i][0]);
        chk("data_known", $isunknown(dout(i)), 0);
        if (q[i].size() != 0) any = 1;
      end
      chk("in_ready", bus.inbound_ready_o, q[bus.inbound_dir_i].size() < D);
      chk("idle", idle_o, !any && !bus.inbound_valid_i);
      if (stall && bus.inbound_valid_i && !rst_i) begin
        chk("up_stable_data", bus.inbound_data_i, s_data);
        chk("up_stable_dir", bus.inbound_dir_i, s_dir);
      end
    end
    stall = bus.inbound_valid_i && !bus.inbound_ready_o && !rst_i;
    s_data = bus.inbound_data_i;
    s_dir = bus.inbound_dir_i;
  end
  initial begin
    logic [W-1:0] t2[4];
    t2 = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    drive(0, 0, 0);
    set_rdy(4'hF);
    repeat (2) tick;
    rst_i = 0;
    chk_en = 1;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", vld(i), 0);
      chk("rst_data", dout(i), 0);
    end
    chk("rst_ready", bus.inbound_ready_o, 1);
    chk("rst_idle", idle_o, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), t2[i]);
      tick;
      if (i == 3) drive(0, 0, 0);
      @(negedge clk_i);
      chk("seq_valid", vld(i), 1);
      chk("seq_data", dout(i), t2[i]);
    end
    tick;
    @(negedge clk_i);
    chk("seq_idle", idle_o, 1);
    set_rdy(4'b1101);
    drive(1, 1, 32'h10);
    tick;
    drive(1, 1, 32'h11);
    tick;
    drive(1, 1, 32'h12);
    @(negedge clk_i);
    chk("east_full_ready", bus.inbound_ready_o, 0);
    chk("east_head0", dout(1), 32'h10);
    tick;
    @(negedge clk_i);
    chk("east_still_blocked", bus.inbound_ready_o, 0);
    set_rdy(4'hF);
    #1;
    chk("east_pop_no_free", bus.inbound_ready_o, 0);
    tick;
    @(negedge clk_i);
    chk("east_head1", dout(1), 32'h11);
    chk("east_ready_back", bus.inbound_ready_o, 1);
    tick;
    drive(1, 0, 32'h13);
    @(negedge clk_i);
    chk("east_head2", dout(1), 32'h12);
    tick;
    drive(0, 0, 0);
    @(negedge clk_i);
    chk("north_after", dout(0), 32'h13);
    tick;
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, W'(i));
      tick;
      @(negedge clk_i);
      chk("west_valid", vld(3), 1);
      chk("west_data", dout(3), W'(i));
      chk("west_ready", bus.inbound_ready_o, 1);
    end
    drive(0, 0, 0);
    tick;
    @(negedge clk_i);
    chk("west_idle", idle_o, 1);
    set_rdy(4'b1011);
    drive(1, 2, 32'h20);
    tick;
    drive(1, 2, 32'h21);
    tick;
    drive(1, 2, 32'h22);
    @(negedge clk_i);
    chk("south_full", bus.inbound_ready_o, 0);
    chk("south_head0", dout(2), 32'h20);
    set_rdy(4'hF);
    #1;
    chk("south_pop_push_refused", bus.inbound_ready_o, 0);
    tick;
    @(negedge clk_i);
    chk("south_head1", dout(2), 32'h21);
    chk("south_ready_next", bus.inbound_ready_o, 1);
    tick;
    drive(0, 0, 0);
    @(negedge clk_i);
    chk("south_head2", dout(2), 32'h22);
    tick;
    set_rdy(4'b1010);
    drive(1, 0, 32'h30);
    tick;
    drive(1, 0, 32'h31);
    tick;
    drive(1, 2, 32'h32);
    tick;
    drive(0, 0, 0);
    @(negedge clk_i);
    chk("pre_rst_north", vld(0), 1);
    chk("pre_rst_south", vld(2), 1);
    rst_i = 1;
    tick;
    rst_i = 0;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_valid", vld(i), 0);
      chk("mid_rst_data", dout(i), 0);
    end
    chk("mid_rst_idle", idle_o, 1);
    set_rdy(4'hF);
    repeat (5) tick;
    for (int n = 0; n < 3000; n++) begin
      set_rdy({4{1'b0}} | {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
      if (!(bus.inbound_valid_i && !m_acc))
        drive(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom));
      tick;
    end
    drive(0, 0, 0);
    set_rdy(4'hF);
    repeat (5) tick;
    @(negedge clk_i);
    chk("final_idle", idle_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
